pipeline_ctrl: RTL

Central hazard and sequencing controller for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB). It produces the per-stage write enables that replace the single global pipeline_advance, inserts bubbles and flushes, and selects EX operand forwarding. It keeps a registered scoreboard of the destination registers in EX, MEM and WB, and counts stall and flush cycles for performance debug.

---
 rtl/pipeline_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the 5-stage RV32 pipeline (per-stage enables, flush, bubble, EX forwarding).
// Latency: enables/selects/flush are combinational from the slot scoreboard; scoreboard and perf counters update on clk.
// Backpressure: ext_stall freezes every stage; a hazard holds PC and IF/ID and bubbles ID/EX; a taken branch squashes IF/ID and ID/EX.
//
// Build option: define PIPELINE_CTRL_FWD_EN to enable EX operand forwarding (only load-use then stalls).
//   Without it fwd_a_sel/fwd_b_sel stay 00 and ID waits until no in-flight writer matches its sources.
// Ports:
//   clk, rst (sync, active-low)        clock and reset
//   ext_stall, ex_branch_taken         freeze request, EX redirect
//   id_valid, id_rs1/2, id_use_rs1/2,  ID instruction fields
//   id_rd, id_rd_wr, id_is_load
//   pc_en, pc_load, if_id_en/flush,    per-stage write enables, flush and bubble
//   id_ex_en/bubble, ex_mem_en, mem_wb_en
//   fwd_a_sel, fwd_b_sel               EX operand source: 00 ID/EX, 01 MEM, 10 WB
//   stall_cnt, flush_cnt               saturating perf counters
module pipeline_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ext_stall,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_wr,
  input  logic                  id_is_load,
  input  logic                  ex_branch_taken,
  output logic                  pc_en,
  output logic                  pc_load,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
);

`ifdef PIPELINE_CTRL_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_wr;
  } slot_t;

  // The load flag only matters while the producer sits in EX, so MEM/WB do not carry it.
  slot_t                 ex_slot, mem_slot, wb_slot;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2;
  logic                  ex_use_rs1, ex_use_rs2;

  logic ex_wr, mem_wr, wb_wr;
  logic dep_ex, dep_mem, dep_wb;
  logic hazard;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // x0 is never a producer.
  assign ex_wr  = ex_slot.vld  && ex_slot.rd_wr  && (ex_slot.rd  != '0);
  assign mem_wr = mem_slot.vld && mem_slot.rd_wr && (mem_slot.rd != '0);
  assign wb_wr  = wb_slot.vld  && wb_slot.rd_wr  && (wb_slot.rd  != '0);

  assign dep_ex  = (id_use_rs1 && ex_wr  && (id_rs1 == ex_slot.rd))  || (id_use_rs2 && ex_wr  && (id_rs2 == ex_slot.rd));
  assign dep_mem = (id_use_rs1 && mem_wr && (id_rs1 == mem_slot.rd)) || (id_use_rs2 && mem_wr && (id_rs2 == mem_slot.rd));
  assign dep_wb  = (id_use_rs1 && wb_wr  && (id_rs1 == wb_slot.rd))  || (id_use_rs2 && wb_wr  && (id_rs2 == wb_slot.rd));

  // With the bypass network only a load still in EX is too late; without it any in-flight writer blocks ID.
  assign hazard = id_valid && (FWD_EN ? (dep_ex && ex_is_load) : (dep_ex || dep_mem || dep_wb));

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
    if (ex_slot.vld && ex_use_rs1) begin
      if (mem_wr && (ex_rs1 == mem_slot.rd))     fwd_a_raw = 2'b01;
      else if (wb_wr && (ex_rs1 == wb_slot.rd))  fwd_a_raw = 2'b10;
    end
    if (ex_slot.vld && ex_use_rs2) begin
      if (mem_wr && (ex_rs2 == mem_slot.rd))     fwd_b_raw = 2'b01;
      else if (wb_wr && (ex_rs2 == wb_slot.rd))  fwd_b_raw = 2'b10;
    end
  end

  assign fwd_a_sel = FWD_EN ? fwd_a_raw : 2'b00;
  assign fwd_b_sel = FWD_EN ? fwd_b_raw : 2'b00;

  // Priority: ext_stall > taken branch > hazard stall > advance.
  always_comb begin
    pc_en        = 1'b1;
    pc_load      = 1'b0;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if (ext_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (ex_branch_taken) begin
      pc_load      = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (hazard) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_slot    <= '0;
      mem_slot   <= '0;
      wb_slot    <= '0;
      ex_is_load <= 1'b0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_use_rs1 <= 1'b0;
      ex_use_rs2 <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else if (!ext_stall) begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      if (ex_branch_taken || hazard) begin
        // Bubble: clear every EX field so stale use bits cannot drive forwarding.
        ex_slot    <= '0;
        ex_is_load <= 1'b0;
        ex_rs1     <= '0;
        ex_rs2     <= '0;
        ex_use_rs1 <= 1'b0;
        ex_use_rs2 <= 1'b0;
      end else begin
        ex_slot.vld   <= id_valid;
        ex_slot.rd    <= id_rd;
        ex_slot.rd_wr <= id_rd_wr;
        ex_is_load    <= id_is_load;
        ex_rs1        <= id_rs1;
        ex_rs2        <= id_rs2;
        ex_use_rs1    <= id_use_rs1;
        ex_use_rs2    <= id_use_rs2;
      end
      if (ex_branch_taken && (flush_cnt != '1))
        flush_cnt <= flush_cnt + PERF_CNT_W'(1);
      if (!ex_branch_taken && hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + PERF_CNT_W'(1);
    end
  end

endmodule
